dm_responder: RTL

- Data-memory responder for the multi-cycle CPU. It answers the active-low nRD/nWR strobes that the control unit drives during the sMEM state.
- Stores 32-bit words in byte-addressed, big-endian storage.
- Supports a parameterised number of wait states, a one-cycle `ready`/`err` completion pulse, and abort on strobe withdrawal.
- Sits between the CU/ALU-result address path and the DB mux (FromDM input).

---
 rtl/dm_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the multi-cycle CPU.
// It answers the active-low nRD/nWR strobes that the control unit drives
// during sMEM. Storage is byte-addressed and big-endian, and it returns
// 32-bit words.
//
// Handshake: a request is sampled on a rising CLK edge while exactly one
// strobe is low. The access happens WAIT_CYCLES edges later, and `ready`
// (with `err` on an illegal request) is high for exactly the following
// cycle. If the strobe is withdrawn, the strobe type changes, or addr moves
// during the wait, the request is dropped: no access and no pulse.
//
// Optional build macro DM_CLEAR_ON_RST_EN: when defined, nRST also clears
// every storage byte to 0x00. Otherwise storage is never reset.
//
// FSM state is visible hierarchically through `state` (S_IDLE=0, S_WAIT=1,
// S_DONE=2).
module dm_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        nRD,
  input  logic        nWR,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [3:0]  cnt;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic        err_flag;

  // Request decode
  logic        req_any;
  logic        req_legal;
  logic        hold;

  // Access control, produced by the next-state logic
  logic          do_acc;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic          start_wait;
  logic          set_err;

  // Byte lanes of the addressed word (the address is aligned, so OR is add)
  logic [AW-1:0] b0;
  logic [AW-1:0] b1;
  logic [AW-1:0] b2;
  logic [AW-1:0] b3;

  // Classify the current strobe/address combination
  always_comb begin
    req_any   = !nRD || !nWR;
    req_legal = (nRD != nWR) && (addr[1:0] == 2'b00) &&
                (addr < 32'(DEPTH_BYTES));
    if (lat_wr) begin
      hold = !nWR && nRD && (addr == lat_addr);
    end else begin
      hold = !nRD && nWR && (addr == lat_addr);
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and access decision
  always_comb begin
    state_nxt  = state;
    do_acc     = 1'b0;
    acc_wr     = 1'b0;
    acc_addr   = addr[AW-1:0];
    start_wait = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          if (!req_legal) begin
            state_nxt = S_DONE;
            set_err   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            do_acc    = 1'b1;
            acc_wr    = !nWR;
            state_nxt = S_DONE;
          end else begin
            start_wait = 1'b1;
            state_nxt  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!hold) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd1) begin
          do_acc    = 1'b1;
          acc_wr    = lat_wr;
          acc_addr  = lat_addr[AW-1:0];
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Completion outputs come straight from the state flops
  always_comb begin
    ready = (state == S_DONE);
    err   = (state == S_DONE) && err_flag;
  end

  // Byte-lane addresses for the big-endian word
  always_comb begin
    b0 = acc_addr;
    b1 = acc_addr | AW'(1);
    b2 = acc_addr | AW'(2);
    b3 = acc_addr | AW'(3);
  end

  // Request latch, wait counter, error flag and read data
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= 4'd0;
      lat_wr   <= 1'b0;
      lat_addr <= 32'd0;
      err_flag <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      if (start_wait) begin
        cnt      <= 4'(WAIT_CYCLES);
        lat_wr   <= !nWR;
        lat_addr <= addr;
      end else if (state == S_WAIT && hold) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nxt == S_DONE) begin
        err_flag <= set_err;
      end
      if (do_acc && !acc_wr) begin
        rdata <= {mem[b0], mem[b1], mem[b2], mem[b3]};
      end
    end
  end

`ifdef DM_CLEAR_ON_RST_EN
  // Storage writes; reset wipes every byte
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_acc && acc_wr) begin
      mem[b0] <= wdata[31:24];
      mem[b1] <= wdata[23:16];
      mem[b2] <= wdata[15:8];
      mem[b3] <= wdata[7:0];
    end
  end
`else
  // Storage writes; contents survive reset
  always_ff @(posedge CLK) begin
    if (do_acc && acc_wr) begin
      mem[b0] <= wdata[31:24];
      mem[b1] <= wdata[23:16];
      mem[b2] <= wdata[15:8];
      mem[b3] <= wdata[7:0];
    end
  end
`endif

endmodule
